regfile_sel_2r1w: RTL and testbench
===================================

Name: regfile_sel_2r1w

Overview:
- Parametrised successor to the CPU's 16:1 register-select mux.
- Holds the register storage itself and provides two independently addressed, registered read ports (A, B) and one write port.
- Sits between decode and the ALU: port A feeds Rsrc, port B feeds Rdest.
- Same-cycle write data is forwarded to the reads so the datapath sees no read-after-write hazard.

Parameters:
- DATA_W, 16, width of each register and of all data ports.
- NUM_REGS, 16, number of registers; must be a power of two, at least 2.
- ADDR_W, 4, address width; must equal log2(NUM_REGS). Elaboration fails via a generate-time check otherwise.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  write strobe.
- wr_addr  input  ADDR_W  write register index.
- wr_data  input  DATA_W  write data.
- rd_en_a  input  1  port A read request.
- rd_addr_a  input  ADDR_W  port A register index.
- rd_data_a  output  DATA_W  port A registered read data.
- rd_valid_a  output  1  port A data-valid flag.
- rd_en_b  input  1  port B read request.
- rd_addr_b  input  ADDR_W  port B register index.
- rd_data_b  output  DATA_W  port B registered read data.
- rd_valid_b  output  1  port B data-valid flag.

Behaviour:
- Reset:
  - The design has one clock; reset is synchronous and active-high.
  - With reset high at a rising edge: all NUM_REGS registers become 0, rd_data_a and rd_data_b become 0, rd_valid_a and rd_valid_b become 0.
  - Reset overrides any write or read presented in that cycle.
- Write:
  - wr_en=1 at edge N: reg[wr_addr] takes wr_data at edge N.
  - wr_en=0: storage is unchanged.
- Read (per port, A and B identical and independent):
  - Latency is 1 cycle. rd_en=1 at edge N: rd_data is valid after edge N and rd_valid=1 for that cycle.
  - rd_en=0 at edge N: rd_data holds its previous value and rd_valid=0.
  - rd_data never changes unless rd_en=1 or reset=1.
- Write-first bypass:
  - Condition: rd_en=1, wr_en=1 and rd_addr==wr_addr at the same edge.
  - Response: rd_data takes wr_data, not the old contents.
  - Applies to both ports at once when both match.
- Simultaneous events:
  - Both ports may read the same address in the same cycle; both return identical data.
  - Reads of addresses not being written return the pre-edge contents.
- No handshake back-pressure: every request is accepted every cycle.
- Structure:
  - Read selection is a NUM_REGS:1 tree built by a generate loop, with no hand-instantiated leaves.
  - The final selection is registered; the combinational depth is log2(NUM_REGS) mux levels.
- Reset mid-operation:
  - A read issued in the reset cycle is discarded; rd_valid stays 0 the next cycle.
  - A write issued in the reset cycle is lost.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined:
  - Register 0 is hardwired to 0; writes to address 0 are ignored.
  - Reads of address 0 return 0, including the bypass case with wr_addr=0.
- Undefined: register 0 is an ordinary register, identical to the others.

Test Plan:
1. Reset: reset=1 for 2 cycles, then rd_en_a=1 with addr 5 -> next cycle rd_data_a=0x0000, rd_valid_a=1.
2. Write then read:
   - Stimulus: write 0xBEEF to reg 3 at edge N; at edge N+1, rd_en_a=1 addr 3 and rd_en_b=1 addr 3.
   - Response: after N+1, rd_data_a=rd_data_b=0xBEEF and both valids are 1.
3. Bypass:
   - Stimulus: reg 7=0x1111; in the same cycle, write 0x2222 to reg 7 and read addr 7 on A.
   - Response: rd_data_a=0x2222 next cycle. Port B reading addr 6 (holding 0x0606) returns 0x0606.
4. Hold: after rd_data_a=0xBEEF, drive rd_en_a=0 for 3 cycles while writing reg 3=0x0000 -> rd_data_a stays 0xBEEF, rd_valid_a=0.
5. Reset mid-operation:
   - Stimulus: reset=1 at the same edge as a write of 0xAAAA to reg 9 and a read on B.
   - Response: rd_valid_b=0 next cycle; a later read of reg 9 returns 0x0000.
6. REGFILE_ZERO_REG_EN:
   - Defined: write 0xFFFF to reg 0 while reading addr 0 -> returns 0x0000, and a later read also returns 0x0000.
   - Undefined: same stimulus -> returns 0xFFFF on both reads.
   - Repeat with NUM_REGS=32, DATA_W=32, writing 0xDEADBEEF to reg 31 -> read back 0xDEADBEEF.

Source files
------------

// File: rtl/regfile_sel_2r1w.sv
// ============================================================================
// regfile_sel_2r1w : register file with two registered read ports and one write
// port. Reads are selected through a generated NUM_REGS:1 tree and use
// write-first bypass. `REGFILE_ZERO_REG_EN hardwires register 0 to zero.
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_sel_2r1w #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              rd_valid_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid_b
);

  localparam int NODES = 2 * NUM_REGS - 1;

  if (NUM_REGS < 2 || (NUM_REGS & (NUM_REGS - 1)) != 0 ||
      ADDR_W != $clog2(NUM_REGS)) begin : g_param_check
    $error("regfile_sel_2r1w: NUM_REGS must be a power of two >= 2 and ADDR_W = log2(NUM_REGS)");
  end

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] rd_data_q [2];
  logic [DATA_W-1:0] rd_data_d [2];
  logic [1:0]        rd_valid_q;
  logic [1:0]        rd_valid_d;

  logic              w_wr_fire;
  logic [1:0]        w_rd_en;
  logic [ADDR_W-1:0] w_rd_addr [2];
  logic [DATA_W-1:0] w_sel [2];

`ifdef REGFILE_ZERO_REG_EN
  assign w_wr_fire = wr_en && (wr_addr != '0);
`else
  assign w_wr_fire = wr_en;
`endif

  assign w_rd_en      = {rd_en_b, rd_en_a};
  assign w_rd_addr[0] = rd_addr_a;
  assign w_rd_addr[1] = rd_addr_b;

  always_comb begin
    regs_d = regs_q;
    if (w_wr_fire) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  // Heap-ordered tree: node i has children 2i+1 / 2i+2; root decodes the MSB.
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [DATA_W-1:0] w_node [NODES];

    for (genvar j = 0; j < NUM_REGS; j++) begin : g_leaf
`ifdef REGFILE_ZERO_REG_EN
      if (j == 0) begin : g_zero
        assign w_node[NUM_REGS-1+j] = '0;
      end else begin : g_reg
        assign w_node[NUM_REGS-1+j] = regs_q[j];
      end
`else
      assign w_node[NUM_REGS-1+j] = regs_q[j];
`endif
    end

    for (genvar i = 0; i < NUM_REGS - 1; i++) begin : g_node
      localparam int DEPTH = $clog2(i + 2) - 1;
      assign w_node[i] = w_rd_addr[p][ADDR_W-1-DEPTH] ? w_node[2*i+2] : w_node[2*i+1];
    end

    assign w_sel[p] = w_node[0];
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data_d[p] = rd_data_q[p];
      if (w_rd_en[p]) begin
        rd_data_d[p] = (w_wr_fire && (wr_addr == w_rd_addr[p])) ? wr_data : w_sel[p];
      end
    end
    rd_valid_d = w_rd_en;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q     <= '{default: '0};
      rd_data_q  <= '{default: '0};
      rd_valid_q <= '0;
    end else begin
      regs_q     <= regs_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data_a  = rd_data_q[0];
  assign rd_data_b  = rd_data_q[1];
  assign rd_valid_a = rd_valid_q[0];
  assign rd_valid_b = rd_valid_q[1];

endmodule

`default_nettype wire

// File: tb/tb_regfile_sel_2r1w.sv
// ============================================================================
// tb_regfile_sel_2r1w : table-driven bench for the 16x16 build plus a short
// hand-written sequence on a 32x32 instance.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_regfile_sel_2r1w;

`ifdef REGFILE_ZERO_REG_EN
  localparam logic [15:0] Z16 = 16'h0000;
  localparam logic [31:0] Z32 = 32'h0000_0000;
`else
  localparam logic [15:0] Z16 = 16'hFFFF;
  localparam logic [31:0] Z32 = 32'hFFFF_FFFF;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 16x16 instance
  logic        rst = 1'b1, we = 1'b0, ea = 1'b0, eb = 1'b0;
  logic [3:0]  wa = '0, aa = '0, ab = '0;
  logic [15:0] wd = '0;
  logic [15:0] da, db;
  logic        va, vb;

  regfile_sel_2r1w dut (
    .clk(clk), .reset(rst),
    .wr_en(we), .wr_addr(wa), .wr_data(wd),
    .rd_en_a(ea), .rd_addr_a(aa), .rd_data_a(da), .rd_valid_a(va),
    .rd_en_b(eb), .rd_addr_b(ab), .rd_data_b(db), .rd_valid_b(vb)
  );

  // 32x32 instance
  logic        rst2 = 1'b1, we2 = 1'b0, ea2 = 1'b0, eb2 = 1'b0;
  logic [4:0]  wa2 = '0, aa2 = '0, ab2 = '0;
  logic [31:0] wd2 = '0;
  logic [31:0] da2, db2;
  logic        va2, vb2;

  regfile_sel_2r1w #(.DATA_W(32), .NUM_REGS(32), .ADDR_W(5)) dut32 (
    .clk(clk), .reset(rst2),
    .wr_en(we2), .wr_addr(wa2), .wr_data(wd2),
    .rd_en_a(ea2), .rd_addr_a(aa2), .rd_data_a(da2), .rd_valid_a(va2),
    .rd_en_b(eb2), .rd_addr_b(ab2), .rd_data_b(db2), .rd_valid_b(vb2)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic        ea;
    logic [3:0]  aa;
    logic        eb;
    logic [3:0]  ab;
    logic        xva;
    logic [15:0] xda;
    logic        xvb;
    logic [15:0] xdb;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_err    = 0;

  function automatic vec_t mk(input logic r, input logic w, input logic [3:0] a_w,
                              input logic [15:0] d_w, input logic e_a, input logic [3:0] a_a,
                              input logic e_b, input logic [3:0] a_b, input logic x_va,
                              input logic [15:0] x_da, input logic x_vb, input logic [15:0] x_db);
    vec_t v;
    v.rst = r;  v.we = w;  v.wa = a_w;  v.wd = d_w;
    v.ea = e_a; v.aa = a_a; v.eb = e_b; v.ab = a_b;
    v.xva = x_va; v.xda = x_da; v.xvb = x_vb; v.xdb = x_db;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //                 rst   we    wa     wd         ea    aa     eb    ab     xva   xda        xvb   xdb
    vecs.push_back(mk(1'b1, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0,  1'b0, 4'd0,  1'b0, 16'h0000, 1'b0, 16'h0000));
    vecs.push_back(mk(1'b1, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0,  1'b0, 4'd0,  1'b0, 16'h0000, 1'b0, 16'h0000));
    vecs.push_back(mk(1'b0, 1'b0, 4'd0,  16'h0000, 1'b1, 4'd5,  1'b0, 4'd0,  1'b1, 16'h0000, 1'b0, 16'h0000));
    vecs.push_back(mk(1'b0, 1'b1, 4'd3,  16'hBEEF, 1'b0, 4'd0,  1'b0, 4'd0,  1'b0, 16'h0000, 1'b0, 16'h0000));
    vecs.push_back(mk(1'b0, 1'b0, 4'd0,  16'h0000, 1'b1, 4'd3,  1'b1, 4'd3,  1'b1, 16'hBEEF, 1'b1, 16'hBEEF));
    vecs.push_back(mk(1'b0, 1'b1, 4'd7,  16'h1111, 1'b0, 4'd0,  1'b0, 4'd0,  1'b0, 16'hBEEF, 1'b0, 16'hBEEF));
    vecs.push_back(mk(1'b0, 1'b1, 4'd6,  16'h0606, 1'b0, 4'd0,  1'b0, 4'd0,  1'b0, 16'hBEEF, 1'b0, 16'hBEEF));
    // bypass on A, untouched register on B
    vecs.push_back(mk(1'b0, 1'b1, 4'd7,  16'h2222, 1'b1, 4'd7,  1'b1, 4'd6,  1'b1, 16'h2222, 1'b1, 16'h0606));
    vecs.push_back(mk(1'b0, 1'b0, 4'd0,  16'h0000, 1'b1, 4'd3,  1'b0, 4'd0,  1'b1, 16'hBEEF, 1'b0, 16'h0606));
    // hold A for three cycles while reg 3 is cleared
    vecs.push_back(mk(1'b0, 1'b1, 4'd3,  16'h0000, 1'b0, 4'd3,  1'b0, 4'd0,  1'b0, 16'hBEEF, 1'b0, 16'h0606));
    vecs.push_back(mk(1'b0, 1'b1, 4'd3,  16'h0000, 1'b0, 4'd3,  1'b0, 4'd0,  1'b0, 16'hBEEF, 1'b0, 16'h0606));
    vecs.push_back(mk(1'b0, 1'b1, 4'd3,  16'h0000, 1'b0, 4'd3,  1'b0, 4'd0,  1'b0, 16'hBEEF, 1'b0, 16'h0606));
    vecs.push_back(mk(1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0,  1'b1, 4'd3,  1'b0, 16'hBEEF, 1'b1, 16'h0000));
    vecs.push_back(mk(1'b0, 1'b1, 4'd4,  16'h1234, 1'b1, 4'd4,  1'b1, 4'd4,  1'b1, 16'h1234, 1'b1, 16'h1234));
    vecs.push_back(mk(1'b0, 1'b0, 4'd0,  16'h0000, 1'b1, 4'd4,  1'b1, 4'd7,  1'b1, 16'h1234, 1'b1, 16'h2222));
    // reset overrides a write to reg 9 and reads on both ports
    vecs.push_back(mk(1'b1, 1'b1, 4'd9,  16'hAAAA, 1'b1, 4'd7,  1'b1, 4'd9,  1'b0, 16'h0000, 1'b0, 16'h0000));
    vecs.push_back(mk(1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0,  1'b0, 4'd0,  1'b0, 16'h0000, 1'b0, 16'h0000));
    vecs.push_back(mk(1'b0, 1'b0, 4'd0,  16'h0000, 1'b1, 4'd7,  1'b1, 4'd9,  1'b1, 16'h0000, 1'b1, 16'h0000));
    // register 0 behaviour depends on the zero-register build option
    vecs.push_back(mk(1'b0, 1'b1, 4'd0,  16'hFFFF, 1'b1, 4'd0,  1'b0, 4'd0,  1'b1, Z16,      1'b0, 16'h0000));
    vecs.push_back(mk(1'b0, 1'b0, 4'd0,  16'h0000, 1'b1, 4'd0,  1'b1, 4'd0,  1'b1, Z16,      1'b1, Z16));
    vecs.push_back(mk(1'b0, 1'b1, 4'd15, 16'h5A5A, 1'b1, 4'd14, 1'b1, 4'd15, 1'b1, 16'h0000, 1'b1, 16'h5A5A));
    vecs.push_back(mk(1'b0, 1'b0, 4'd0,  16'h0000, 1'b1, 4'd15, 1'b0, 4'd0,  1'b1, 16'h5A5A, 1'b0, 16'h5A5A));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
      ea  = vecs[i].ea;  aa = vecs[i].aa; eb = vecs[i].eb; ab = vecs[i].ab;
      @(posedge clk);
      #1;
      check($sformatf("v%0d.valid_a", i), {31'd0, va}, {31'd0, vecs[i].xva});
      check($sformatf("v%0d.data_a", i),  {16'd0, da}, {16'd0, vecs[i].xda});
      check($sformatf("v%0d.valid_b", i), {31'd0, vb}, {31'd0, vecs[i].xvb});
      check($sformatf("v%0d.data_b", i),  {16'd0, db}, {16'd0, vecs[i].xdb});
    end
    @(negedge clk);
    we = 1'b0; ea = 1'b0; eb = 1'b0;

    // 32x32 instance: reset, bypass at the top address, read-back, register 0
    @(negedge clk); rst2 = 1'b1;
    @(negedge clk); rst2 = 1'b1;
    @(posedge clk); #1;
    check("w32.reset_valid_a", {31'd0, va2}, 32'd0);
    check("w32.reset_data_a", da2, 32'd0);

    @(negedge clk);
    rst2 = 1'b0; we2 = 1'b1; wa2 = 5'd31; wd2 = 32'hDEAD_BEEF; ea2 = 1'b1; aa2 = 5'd31;
    @(posedge clk); #1;
    check("w32.bypass31_a", da2, 32'hDEAD_BEEF);
    check("w32.bypass31_valid_b", {31'd0, vb2}, 32'd0);

    @(negedge clk);
    we2 = 1'b0; ea2 = 1'b1; aa2 = 5'd31; eb2 = 1'b1; ab2 = 5'd31;
    @(posedge clk); #1;
    check("w32.read31_a", da2, 32'hDEAD_BEEF);
    check("w32.read31_b", db2, 32'hDEAD_BEEF);
    check("w32.read31_valid_b", {31'd0, vb2}, 32'd1);

    @(negedge clk);
    we2 = 1'b1; wa2 = 5'd0; wd2 = 32'hFFFF_FFFF; ea2 = 1'b1; aa2 = 5'd0; eb2 = 1'b1; ab2 = 5'd30;
    @(posedge clk); #1;
    check("w32.reg0_bypass_a", da2, Z32);
    check("w32.reg30_b", db2, 32'd0);

    @(negedge clk);
    we2 = 1'b0; ea2 = 1'b0; eb2 = 1'b1; ab2 = 5'd0;
    @(posedge clk); #1;
    check("w32.reg0_read_b", db2, Z32);
    check("w32.hold_a", da2, Z32);
    check("w32.hold_valid_a", {31'd0, va2}, 32'd0);

    @(negedge clk);
    eb2 = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
